qtable_pkt_parser: RTL and testbench

//  Upstream stage of the Q-table updater. Takes the received-packet byte stream, assembles the

---
 rtl/qtable_pkg.sv | 25 ++
 rtl/qtable_sat_counter.sv | 28 ++
 rtl/qtable_pkt_parser.sv | 167 ++++++++++++++++
 tb/tb_qtable_pkt_parser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/qtable_pkg.sv
// rtl/qtable_pkg.sv - shared widths, packet-type codes and parser state encoding
package qtable_pkg;

    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;
    localparam int PKT_LEN    = 10;

    localparam logic [2:0] PT_HELLO  = 3'd1;
    localparam logic [2:0] PT_JOIN   = 3'd2;
    localparam logic [2:0] PT_UPDATE = 3'd3;
    localparam logic [2:0] PT_DATA   = 3'd4;

    typedef enum logic [2:0] {
        S_HDR,
        S_BODY,
        S_CSUM,
        S_ISSUE,
        S_WAIT
    } state_e;

    function automatic logic type_ok(input logic [2:0] t);
        return (t >= PT_HELLO) && (t <= PT_DATA);
    endfunction

endpackage

// File: rtl/qtable_sat_counter.sv
// rtl/qtable_sat_counter.sv - saturating event counter, holds at all-ones
module qtable_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/qtable_pkt_parser.sv
// rtl/qtable_pkt_parser.sv - byte-stream packet parser feeding the Q-table updater
module qtable_pkt_parser
    import qtable_pkg::*;
#(
    parameter int BYTE_W  = MEM_WIDTH,
    parameter int WORD_W  = WORD_WIDTH,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic [WORD_W-1:0] fSourceID,
    output logic [WORD_W-1:0] fClusterID,
    output logic [WORD_W-1:0] fEnergyLeft,
    output logic [WORD_W-1:0] fQValue,
    output logic [2:0]        fPacketType,
    output logic              upd_en,
    input  logic              upd_done,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              err_flag
);

    localparam int FIELD_W  = 4 * WORD_W;
    localparam int LAST_IDX = PKT_LEN - 2;
    localparam int GAP_W    = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [2:0]          type_q, type_d;
    logic [3:0]          idx_q, idx_d;
    logic [FIELD_W-1:0]  body_q, body_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WORD_W-1:0]   src_q, src_d, clu_q, clu_d, en_q, en_d, qv_q, qv_d;
    logic [2:0]          ptype_q, ptype_d;
    logic                err_q, err_d;
    logic                timed_out, accept, pkt_inc, drop_inc;

    // The abort cycle also closes in_ready so a byte landing on it is not consumed.
    assign timed_out = (gap_q == GAP_W'(TIMEOUT));
    assign in_ready  = (state_q == S_HDR) ||
                       (((state_q == S_BODY) || (state_q == S_CSUM)) && !timed_out);
    assign accept    = in_valid && in_ready;
    assign upd_en    = (state_q == S_ISSUE);

    always_comb begin
        state_d  = state_q;
        csum_d   = csum_q;
        type_d   = type_q;
        idx_d    = idx_q;
        body_d   = body_q;
        gap_d    = gap_q;
        src_d    = src_q;
        clu_d    = clu_q;
        en_d     = en_q;
        qv_d     = qv_q;
        ptype_d  = ptype_q;
        err_d    = err_q;
        pkt_inc  = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            S_HDR: begin
                if (accept) begin
                    csum_d  = in_data;
                    type_d  = in_data[2:0];
                    idx_d   = 4'd1;
                    gap_d   = '0;
                    state_d = S_BODY;
                end
            end
            S_BODY, S_CSUM: begin
                if (timed_out) begin
                    drop_inc = 1'b1;
                    err_d    = 1'b1;
                    state_d  = S_HDR;
                end else if (!accept) begin
                    gap_d = gap_q + GAP_W'(1);
                end else if (state_q == S_BODY) begin
                    gap_d  = '0;
                    csum_d = csum_q ^ in_data;
                    body_d = {body_q[FIELD_W-BYTE_W-1:0], in_data};
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == 4'(LAST_IDX))
                        state_d = S_CSUM;
                end else begin
                    gap_d = '0;
                    if ((in_data != csum_q) || !type_ok(type_q)) begin
                        drop_inc = 1'b1;
                        err_d    = 1'b1;
                        state_d  = S_HDR;
                    end else begin
                        src_d   = body_q[FIELD_W-1 -: WORD_W];
                        clu_d   = body_q[FIELD_W-WORD_W-1 -: WORD_W];
                        en_d    = body_q[2*WORD_W-1 -: WORD_W];
                        qv_d    = body_q[WORD_W-1:0];
                        ptype_d = type_q;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                pkt_inc = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (upd_done)
                    state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HDR;
            csum_q  <= '0;
            type_q  <= '0;
            idx_q   <= '0;
            body_q  <= '0;
            gap_q   <= '0;
            src_q   <= '0;
            clu_q   <= '0;
            en_q    <= '0;
            qv_q    <= '0;
            ptype_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            csum_q  <= csum_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            body_q  <= body_d;
            gap_q   <= gap_d;
            src_q   <= src_d;
            clu_q   <= clu_d;
            en_q    <= en_d;
            qv_q    <= qv_d;
            ptype_q <= ptype_d;
            err_q   <= err_d;
        end
    end

    qtable_sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pkt_inc),
        .count (pkt_count)
    );

    qtable_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_count)
    );

    assign fSourceID   = src_q;
    assign fClusterID  = clu_q;
    assign fEnergyLeft = en_q;
    assign fQValue     = qv_q;
    assign fPacketType = ptype_q;
    assign err_flag    = err_q;

endmodule

// File: tb/tb_qtable_pkt_parser.sv
// tb/tb_qtable_pkt_parser.sv - directed vector bench for qtable_pkt_parser
module tb_qtable_pkt_parser;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] fSourceID, fClusterID, fEnergyLeft, fQValue;
    logic [2:0]  fPacketType;
    logic        upd_en;
    logic        upd_done;
    logic [15:0] pkt_count, drop_count;
    logic        err_flag;

    int n_vec = 0;
    int n_fail = 0;
    int upd_pulses = 0;

    always #5 clk = ~clk;

    qtable_pkt_parser #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .fSourceID   (fSourceID),
        .fClusterID  (fClusterID),
        .fEnergyLeft (fEnergyLeft),
        .fQValue     (fQValue),
        .fPacketType (fPacketType),
        .upd_en      (upd_en),
        .upd_done    (upd_done),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count),
        .err_flag    (err_flag)
    );

    always @(negedge clk) if (upd_en) upd_pulses++;

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] s, c, e, q;
        logic        corrupt;
        logic [7:0]  bad;
        logic        good;
        int          dly;
        logic [15:0] xs, xc, xe, xq;
        logic [2:0]  xt;
        logic [15:0] xpkt, xdrop;
        logic        xerr;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] mk_pkt(input logic [7:0] hdr, input logic [15:0] s, c, e, q,
                                           input logic corrupt, input logic [7:0] bad);
        logic [71:0] b;
        logic [7:0]  x;
        b = {hdr, s, c, e, q};
        x = 8'h00;
        for (int i = 0; i < 9; i++) x ^= b[71-8*i -: 8];
        return {b, corrupt ? bad : x};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_wait: in_ready got 0 expected 1 within 1000 cycles");
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [79:0] p, input int n);
        for (int i = 0; i < n; i++) send_byte(p[79-8*i -: 8]);
    endtask

    task automatic run_pkt(input logic [79:0] p, input logic good, input int dly);
        int p0, rdy_hi;
        p0 = upd_pulses;
        rdy_hi = 0;
        send_bytes(p, 10);
        if (good) begin
            chk("issue_latency", upd_en, 1);
            in_valid = 1'b1;
            in_data  = 8'h01;
            for (int i = 0; i < dly; i++) begin
                if (in_ready) rdy_hi++;
                @(negedge clk);
            end
            if (in_ready) rdy_hi++;
            chk("wait_ready_low", rdy_hi, 0);
            upd_done = 1'b1;
            @(negedge clk);
            upd_done = 1'b0;
            in_valid = 1'b0;
            chk("ready_after_done", in_ready, 1);
        end else begin
            repeat (3) @(negedge clk);
        end
        chk("upd_pulses", upd_pulses - p0, good ? 1 : 0);
    endtask

    task automatic chk_out(input logic [15:0] s, c, e, q, input logic [2:0] t,
                           input logic [15:0] pk, dr, input logic er);
        chk("fSourceID", fSourceID, s);
        chk("fClusterID", fClusterID, c);
        chk("fEnergyLeft", fEnergyLeft, e);
        chk("fQValue", fQValue, q);
        chk("fPacketType", fPacketType, t);
        chk("pkt_count", pkt_count, pk);
        chk("drop_count", drop_count, dr);
        chk("err_flag", err_flag, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [79:0] p;
        int p0;

        vt[0] = '{8'h01, 16'h0005, 16'h0002, 16'h03E8, 16'h0040, 1'b0, 8'h00, 1'b1, 3,
                  16'h0005, 16'h0002, 16'h03E8, 16'h0040, 3'd1, 16'd1, 16'd0, 1'b0};
        vt[1] = '{8'h01, 16'h0005, 16'h0002, 16'h03E8, 16'h0040, 1'b1, 8'h00, 1'b0, 0,
                  16'h0005, 16'h0002, 16'h03E8, 16'h0040, 3'd1, 16'd1, 16'd1, 1'b1};
        vt[2] = '{8'h07, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0, 8'h00, 1'b0, 0,
                  16'h0005, 16'h0002, 16'h03E8, 16'h0040, 3'd1, 16'd1, 16'd2, 1'b1};
        vt[3] = '{8'h04, 16'hABCD, 16'h0102, 16'hFFFF, 16'h8001, 1'b0, 8'h00, 1'b1, 2,
                  16'hABCD, 16'h0102, 16'hFFFF, 16'h8001, 3'd4, 16'd2, 16'd2, 1'b1};
        vt[4] = '{8'h00, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 8'h00, 1'b0, 0,
                  16'hABCD, 16'h0102, 16'hFFFF, 16'h8001, 3'd4, 16'd2, 16'd3, 1'b1};
        vt[5] = '{8'h05, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 8'h00, 1'b0, 0,
                  16'hABCD, 16'h0102, 16'hFFFF, 16'h8001, 3'd4, 16'd2, 16'd4, 1'b1};
        vt[6] = '{8'hFA, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 8'h00, 1'b1, 1,
                  16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 3'd2, 16'd3, 16'd4, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        upd_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_upd_en", upd_en, 0);
        chk_out(16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 16'd0, 16'd0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            p = mk_pkt(vt[i].hdr, vt[i].s, vt[i].c, vt[i].e, vt[i].q, vt[i].corrupt, vt[i].bad);
            run_pkt(p, vt[i].good, vt[i].dly);
            chk_out(vt[i].xs, vt[i].xc, vt[i].xe, vt[i].xq, vt[i].xt,
                    vt[i].xpkt, vt[i].xdrop, vt[i].xerr);
        end

        // back-to-back packets with a long updater hold-off
        run_pkt(mk_pkt(8'h03, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 8'h00), 1'b1, 20);
        chk_out(16'h0011, 16'h0022, 16'h0033, 16'h0044, 3'd3, 16'd4, 16'd4, 1'b1);
        run_pkt(mk_pkt(8'h01, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b0, 8'h00), 1'b1, 1);
        chk_out(16'h0101, 16'h0202, 16'h0303, 16'h0404, 3'd1, 16'd5, 16'd4, 1'b1);

        // reset while the fifth byte is on the bus
        p = mk_pkt(8'h02, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 1'b0, 8'h00);
        p0 = upd_pulses;
        send_bytes(p, 4);
        in_valid = 1'b1;
        in_data  = p[79-32 -: 8];
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_upd_en", upd_en, 0);
        chk_out(16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_pulse", upd_pulses - p0, 0);
        run_pkt(p, 1'b1, 2);
        chk_out(16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 3'd2, 16'd1, 16'd0, 1'b0);

        // inter-byte timeout on a partial packet
        send_bytes(mk_pkt(8'h01, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b0, 8'h00), 5);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("pre_timeout_ready", in_ready, 1);
        chk("pre_timeout_drop", drop_count, 0);
        @(negedge clk);
        chk("timeout_ready", in_ready, 0);
        @(negedge clk);
        chk("post_timeout_ready", in_ready, 1);
        chk_out(16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 3'd2, 16'd1, 16'd1, 1'b1);
        run_pkt(mk_pkt(8'h04, 16'h4321, 16'h8765, 16'h0F0F, 16'h1234, 1'b0, 8'h00), 1'b1, 1);
        chk_out(16'h4321, 16'h8765, 16'h0F0F, 16'h1234, 3'd4, 16'd2, 16'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
